shared_adder_sched: RTL and testbench

Time-multiplexed scheduler sharing one narrow carry-chain adder slice among several requesters in the PRGA soft-logic datapath. Arbitrates requests round-robin, splits each WIDTH-bit operation into CHUNK-bit slices, feeds them LSB-first through the shared adder and carries between slices in a register. Returns one result per accepted request on a single response channel. Supports add, subtract, unsigned less-than and signed less-than.

---
 rtl/shared_adder_sched.sv | 135 +++++++++++++
 tb/tb_shared_adder_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_adder_sched.sv
// Round-robin scheduler that time-shares one CHUNK-bit carry-chain adder among NUM_REQ requesters.
// Each WIDTH-bit ADD/SUB/LTU/LTS is evaluated LSB-first over K slice passes with a registered carry.
module shared_adder_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int CHUNK   = 8,
    localparam int K      = WIDTH / CHUNK,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data
);

    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_LTU = 2'd2, OP_LTS = 2'd3} op_t;

    state_t             state, state_nxt;
    op_t                op_q;
    logic [ID_W-1:0]    ptr, grant_id, id_q;
    logic               grant_vld, fire, last_slice;
    logic [WIDTH-1:0]   a_q, b_q, res;
    logic [CNT_W-1:0]   cnt;
    logic               carry, sum_msb, a_msb, b_msb;
    logic [CHUNK-1:0]   a_sl, b_sl, sum_sl;
    logic               carry_out;

    // First asserted request at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int               idx;
        logic [ID_W-1:0]  idx_w;
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!grant_vld && req_valid[idx_w]) begin
                grant_vld = 1'b1;
                grant_id  = idx_w;
            end
        end
    end

    assign fire       = (state == IDLE) && grant_vld && rst_n;
    assign last_slice = (cnt == CNT_W'(K - 1));

    // Shared slice adder; B is inverted and carry seeded with 1 for everything but ADD.
    assign a_sl = a_q[cnt*CHUNK +: CHUNK];
    assign b_sl = b_q[cnt*CHUNK +: CHUNK] ^ {CHUNK{op_q != OP_ADD}};
    assign {carry_out, sum_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};

    // State register and control counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fire) begin
                ptr   <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                cnt   <= '0;
                carry <= (req_op[grant_id*2 +: 2] != OP_ADD);
            end else if (state == RUN) begin
                cnt   <= last_slice ? '0 : cnt + 1'b1;
                carry <= carry_out;
            end
        end
    end

    // NOTE: operand/result registers carry no reset; they are only observed in DONE, after being loaded.
    always_ff @(posedge clk) begin
        if (fire) begin
            op_q <= op_t'(req_op[grant_id*2 +: 2]);
            a_q  <= req_a[grant_id*WIDTH +: WIDTH];
            b_q  <= req_b[grant_id*WIDTH +: WIDTH];
            id_q <= grant_id;
        end else if (state == RUN) begin
            res[cnt*CHUNK +: CHUNK] <= sum_sl;
            if (last_slice) begin
                sum_msb <= sum_sl[CHUNK-1];
                a_msb   <= a_q[WIDTH-1];
                b_msb   <= b_q[WIDTH-1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire) state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_data  = '0;
        if (fire) begin
            req_ready[grant_id] = 1'b1;
        end
        if (state == DONE) begin
            rsp_valid = 1'b1;
            rsp_id    = id_q;
            case (op_q)
                OP_ADD, OP_SUB: rsp_data    = res;
                OP_LTU:         rsp_data[0] = ~carry;
                OP_LTS:         rsp_data[0] = sum_msb ^ ((a_msb ^ b_msb) & (a_msb ^ sum_msb));
                default:        rsp_data    = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_adder_sched.sv
// Randomized and directed bench for shared_adder_sched, checked against a plain-arithmetic model.
module tb_shared_adder_sched;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int CHUNK   = 8;
    localparam int K       = WIDTH / CHUNK;
    localparam int ID_W    = 2;
    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, LTU = 2'd2, LTS = 2'd3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid, req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a, req_b;
    logic                     rsp_valid, rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_data;

    int tests = 0;
    int fails = 0;

    shared_adder_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a, b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            LTU:     return (a < b) ? 1 : 0;
            default: return ($signed(a) < $signed(b)) ? 1 : 0;
        endcase
    endfunction

    task automatic set_req(input int id, input logic [1:0] op, input logic [WIDTH-1:0] a, b);
        req_valid[id]            = 1'b1;
        req_op[id*2 +: 2]        = op;
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic randomize_req(input int id);
        req_op[id*2 +: 2]        = 2'($urandom);
        req_a[id*WIDTH +: WIDTH] = $urandom;
        req_b[id*WIDTH +: WIDTH] = $urandom;
    endtask

    // Drop the request and garble its operands, so only handshake-time values can matter.
    task automatic scramble(input int id);
        req_valid[id] = 1'b0;
        randomize_req(id);
    endtask

    // Issue one request with rsp_ready high; lat counts cycles from handshake to rsp_valid (-1 on timeout).
    task automatic issue(input int id, input logic [1:0] op, input logic [WIDTH-1:0] a, b,
                         output int lat, output logic [ID_W-1:0] got_id, output logic [WIDTH-1:0] got_data);
        int c;
        lat      = -1;
        got_id   = 'x;
        got_data = 'x;
        @(negedge clk);
        set_req(id, op, a, b);
        rsp_ready = 1'b1;
        #4;
        c = 0;
        while (req_ready[id] !== 1'b1 && c < 20) begin
            @(negedge clk); #4; c++;
        end
        if (req_ready[id] !== 1'b1) begin
            @(negedge clk);
            scramble(id);
            return;
        end
        @(negedge clk);
        scramble(id);
        #4;
        c = 1;
        while (rsp_valid !== 1'b1 && c < 20) begin
            @(negedge clk); #4; c++;
        end
        if (rsp_valid === 1'b1) begin
            lat      = c;
            got_id   = rsp_id;
            got_data = rsp_data;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if (rsp_id !== '0) begin fails++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        tests++; if (rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_priority: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_add();
        int lat; logic [ID_W-1:0] gid; logic [WIDTH-1:0] gd;
        issue(0, ADD, 32'hFFFF_FFFF, 32'd1, lat, gid, gd);
        tests++; if (lat != K + 1) begin fails++; $display("FAIL add_latency: got %0d expected %0d", lat, K + 1); end
        tests++; if (gd !== 32'h0) begin fails++; $display("FAIL add_data: got %h expected 00000000", gd); end
        tests++; if (gid !== 2'd0) begin fails++; $display("FAIL add_id: got %0d expected 0", gid); end
    endtask

    task automatic test_sub();
        int lat; logic [ID_W-1:0] gid; logic [WIDTH-1:0] gd;
        issue(2, SUB, 32'd5, 32'd7, lat, gid, gd);
        tests++; if (gd !== 32'hFFFF_FFFE) begin fails++; $display("FAIL sub_neg_data: got %h expected fffffffe", gd); end
        tests++; if (gid !== 2'd2) begin fails++; $display("FAIL sub_neg_id: got %0d expected 2", gid); end
        issue(2, SUB, 32'h0001_0000, 32'd1, lat, gid, gd);
        tests++; if (gd !== 32'h0000_FFFF) begin fails++; $display("FAIL sub_borrow_data: got %h expected 0000ffff", gd); end
        tests++; if (lat != K + 1) begin fails++; $display("FAIL sub_latency: got %0d expected %0d", lat, K + 1); end
    endtask

    task automatic test_compare();
        logic [1:0]       ops [5] = '{LTU, LTU, LTU, LTS, LTS};
        logic [WIDTH-1:0] as  [5] = '{32'd3, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [WIDTH-1:0] bs  [5] = '{32'd5, 32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] exp [5] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0};
        int lat; logic [ID_W-1:0] gid; logic [WIDTH-1:0] gd;
        for (int i = 0; i < 5; i++) begin
            issue(i % NUM_REQ, ops[i], as[i], bs[i], lat, gid, gd);
            tests++;
            if (gd !== exp[i] || gid !== ID_W'(i % NUM_REQ)) begin
                fails++;
                $display("FAIL compare_%0d: got id %0d data %h expected id %0d data %h", i, gid, gd, i % NUM_REQ, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] edges [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        int lat; logic [ID_W-1:0] gid; logic [WIDTH-1:0] gd, a, b, exp;
        logic [1:0] op; int id;
        for (int i = 0; i < 30; i++) begin
            id  = $urandom_range(0, NUM_REQ - 1);
            op  = 2'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            exp = model(op, a, b);
            issue(id, op, a, b, lat, gid, gd);
            tests++;
            if (gd !== exp || gid !== ID_W'(id) || lat != K + 1) begin
                fails++;
                $display("FAIL random_%0d op %0d a %h b %h: got id %0d data %h lat %0d expected id %0d data %h lat %0d",
                         i, op, a, b, gid, gd, lat, id, exp, K + 1);
            end
        end
    endtask

    task automatic test_round_robin();
        int hs_id[$], hs_cyc[$];
        logic [WIDTH-1:0] exp_q[$];
        int rsp_ids[$];
        logic [WIDTH-1:0] rsp_dat[$];
        int onehot_bad, last_hs, g;
        onehot_bad = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            randomize_req(i);
            req_valid[i] = 1'b1;
        end
        for (int cyc = 0; cyc < 100 && rsp_ids.size() < 6; cyc++) begin
            #4;
            last_hs = -1;
            if ($countones(req_ready) > 1) onehot_bad++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    last_hs = i;
                    hs_id.push_back(i);
                    hs_cyc.push_back(cyc);
                    exp_q.push_back(model(req_op[i*2 +: 2], req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH]));
                end
            end
            if (rsp_valid === 1'b1) begin
                rsp_ids.push_back(int'(rsp_id));
                rsp_dat.push_back(rsp_data);
            end
            @(negedge clk);
            if (last_hs >= 0) randomize_req(last_hs);
            if (hs_id.size() >= 6) req_valid = '0;
        end
        tests++; if (onehot_bad != 0) begin fails++; $display("FAIL rr_onehot: got %0d bad cycles expected 0", onehot_bad); end
        tests++;
        if (hs_id.size() != 6 || rsp_ids.size() != 6) begin
            fails++;
            $display("FAIL rr_counts: got %0d grants %0d responses expected 6 and 6", hs_id.size(), rsp_ids.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                g = i % NUM_REQ;
                tests++; if (hs_id[i] != g) begin fails++; $display("FAIL rr_grant_%0d: got %0d expected %0d", i, hs_id[i], g); end
                tests++;
                if (rsp_ids[i] != g || rsp_dat[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rr_rsp_%0d: got id %0d data %h expected id %0d data %h", i, rsp_ids[i], rsp_dat[i], g, exp_q[i]);
                end
                if (i > 0) begin
                    tests++;
                    if (hs_cyc[i] - hs_cyc[i-1] != K + 2) begin
                        fails++;
                        $display("FAIL rr_gap_%0d: got %0d expected %0d", i, hs_cyc[i] - hs_cyc[i-1], K + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a0, b0, a1, b1, exp0, exp1;
        int c;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        exp0 = model(SUB, a0, b0);
        exp1 = model(ADD, a1, b1);
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(0, SUB, a0, b0);
        #4;
        c = 0;
        while (req_ready[0] !== 1'b1 && c < 20) begin @(negedge clk); #4; c++; end
        tests++; if (req_ready[0] !== 1'b1) begin fails++; $display("FAIL bp_grant0: got %b expected 1", req_ready[0]); end
        @(negedge clk);
        scramble(0);
        set_req(1, ADD, a1, b1);
        #4;
        c = 0;
        while (rsp_valid !== 1'b1 && c < 20) begin @(negedge clk); #4; c++; end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp0) begin
            fails++;
            $display("FAIL bp_first_rsp: got valid %b id %0d data %h expected valid 1 id 0 data %h", rsp_valid, rsp_id, rsp_data, exp0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #4;
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp0 || req_ready !== '0) begin
                fails++;
                $display("FAIL bp_hold_%0d: got valid %b id %0d data %h ready %b expected 1 0 %h 0000",
                         i, rsp_valid, rsp_id, rsp_data, req_ready, exp0);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #4;
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL bp_release_ready: got %b expected 0000", req_ready); end
        @(negedge clk); #4;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL bp_next_hs: got valid %b ready %b expected 0 0010", rsp_valid, req_ready);
        end
        @(negedge clk);
        scramble(1);
        #4;
        c = 1;
        while (rsp_valid !== 1'b1 && c < 20) begin @(negedge clk); #4; c++; end
        tests++;
        if (rsp_valid !== 1'b1 || c != K + 1 || rsp_id !== 2'd1 || rsp_data !== exp1) begin
            fails++;
            $display("FAIL bp_second_rsp: got lat %0d id %0d data %h expected lat %0d id 1 data %h", c, rsp_id, rsp_data, K + 1, exp1);
        end
    endtask

    task automatic test_reset_abort();
        logic [WIDTH-1:0] a3, b3, exp3;
        int c;
        a3 = $urandom; b3 = $urandom;
        exp3 = model(SUB, a3, b3);
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(1, ADD, $urandom, $urandom);
        #4;
        c = 0;
        while (req_ready[1] !== 1'b1 && c < 20) begin @(negedge clk); #4; c++; end
        tests++; if (req_ready[1] !== 1'b1) begin fails++; $display("FAIL abort_grant: got %b expected 1", req_ready[1]); end
        @(negedge clk); scramble(1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        set_req(3, SUB, a3, b3);
        #4;
        tests++;
        if (req_ready !== '0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_in_reset: got ready %b valid %b expected 0000 0", req_ready, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL abort_after_reset: got valid %b id %0d data %h ready %b expected 0 0 0 1000",
                     rsp_valid, rsp_id, rsp_data, req_ready);
        end
        @(negedge clk);
        scramble(3);
        #4;
        c = 1;
        while (rsp_valid !== 1'b1 && c < 20) begin @(negedge clk); #4; c++; end
        tests++;
        if (rsp_valid !== 1'b1 || c != K + 1 || rsp_id !== 2'd3 || rsp_data !== exp3) begin
            fails++;
            $display("FAIL abort_new_rsp: got lat %0d id %0d data %h expected lat %0d id 3 data %h", c, rsp_id, rsp_data, K + 1, exp3);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_compare();
        test_random();
        test_round_robin();
        test_backpressure();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
